// File: rtl/tower_pkg.sv
// Shared types and constants for tower blocks: state encoding, coordinate widths, location field layout.
// Latency: none (package only).
// Backpressure: none (package only).
package tower_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int LOC_W = X_W + Y_W;

  // car_location = {x, y}
  localparam int LOC_X_LSB = 7;
  localparam int LOC_X_MSB = 14;
  localparam int LOC_Y_LSB = 0;
  localparam int LOC_Y_MSB = 6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMED     = 3'd1,
    S_FIRE      = 3'd2,
    S_COOLDOWN  = 3'd3,
    S_DESTROYED = 3'd4
  } tower_state_t;

  // One-hot debug view {DESTROYED, COOLDOWN, FIRE, ARMED}; IDLE shows nothing.
  function automatic logic [3:0] state_leds(tower_state_t s);
    logic [3:0] leds;
    leds = 4'b0000;
    case (s)
      S_ARMED:     leds = 4'b0001;
      S_FIRE:      leds = 4'b0010;
      S_COOLDOWN:  leds = 4'b0100;
      S_DESTROYED: leds = 4'b1000;
      default:     leds = 4'b0000;
    endcase
    return leds;
  endfunction

endpackage

// File: rtl/tower_range_check.sv
// Combinational square-range test of a car location against a tower position.
// Latency: zero cycles (pure combinational).
// Backpressure: none; result is valid whenever the inputs are.
module tower_range_check import tower_pkg::*; #(
  parameter int RANGE = 20
) (
  input  logic [LOC_W-1:0] location,
  input  logic [X_W-1:0]   tower_x,
  input  logic [Y_W-1:0]   tower_y,
  output logic             in_range
);

  localparam logic [8:0] RANGE_U = 9'(RANGE);

  logic [X_W-1:0]    car_x;
  logic [Y_W-1:0]    car_y;
  logic signed [8:0] dx;
  logic signed [8:0] dy;
  logic [8:0]        abs_dx;
  logic [8:0]        abs_dy;

  // 9-bit signed differences hold the full +/-255 span, so no wrap-around is possible.
  always_comb begin
    car_x    = location[LOC_X_MSB:LOC_X_LSB];
    car_y    = location[LOC_Y_MSB:LOC_Y_LSB];
    dx       = $signed({1'b0, car_x}) - $signed({1'b0, tower_x});
    dy       = $signed({2'b00, car_y}) - $signed({2'b00, tower_y});
    abs_dx   = dx[8] ? $unsigned(-dx) : $unsigned(dx);
    abs_dy   = dy[8] ? $unsigned(-dy) : $unsigned(dy);
    in_range = (abs_dx <= RANGE_U) && (abs_dy <= RANGE_U);
  end

endmodule

// File: rtl/tower_targeting.sv
// Single tower: fires on in-range car positions, tracks car health, frame-counted cooldown. Optional LEDR debug port under TOWER_LEDR_EN.
// Latency: car_done -> fire 1 cycle; decremented health / car_destroyed 2 cycles; initiate -> armed 1 cycle.
// Backpressure: none; car_done is simply ignored whenever the tower is not armed.
module tower_targeting import tower_pkg::*; #(
  parameter int TOWER_X         = 80,
  parameter int TOWER_Y         = 60,
  parameter int RANGE           = 20,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int CAR_HEALTH      = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             initiate,
  input  logic             enable_draw,
  input  logic             car_done,
  input  logic [LOC_W-1:0] car_location,
  output logic             car_destroyed,
  output logic             fire,
  output logic [3:0]       hits_remaining
`ifdef TOWER_LEDR_EN
  ,
  output logic [3:0]       LEDR
`endif
);

  localparam logic [X_W-1:0] TX     = X_W'(TOWER_X);
  localparam logic [Y_W-1:0] TY     = Y_W'(TOWER_Y);
  localparam logic [3:0]     HEALTH = 4'(CAR_HEALTH);
  // A zero cooldown still costs one frame.
  localparam int             CD_EFF  = (COOLDOWN_FRAMES < 1) ? 1 : COOLDOWN_FRAMES;
  localparam logic [7:0]     CD_LAST = 8'(CD_EFF - 1);

  tower_state_t state, state_n;
  logic [7:0]   cd_cnt, cd_cnt_n;
  logic [3:0]   hits_n;
  logic         fire_n;
  logic         destroyed_n;
  logic         in_range;

  tower_range_check #(.RANGE(RANGE)) u_range (
    .location (car_location),
    .tower_x  (TX),
    .tower_y  (TY),
    .in_range (in_range)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  // Next state and next register values; initiate overrides everything else.
  always_comb begin
    state_n     = state;
    cd_cnt_n    = cd_cnt;
    hits_n      = hits_remaining;
    fire_n      = 1'b0;
    destroyed_n = car_destroyed;
    if (initiate) begin
      state_n     = S_ARMED;
      cd_cnt_n    = 8'd0;
      hits_n      = HEALTH;
      destroyed_n = 1'b0;
    end else begin
      case (state)
        S_ARMED: begin
          if (car_done && in_range) begin
            state_n = S_FIRE;
            fire_n  = 1'b1;
          end
        end
        S_FIRE: begin
          hits_n = (hits_remaining == 4'd0) ? 4'd0 : hits_remaining - 4'd1;
          if (hits_remaining <= 4'd1) begin
            state_n     = S_DESTROYED;
            destroyed_n = 1'b1;
          end else begin
            state_n = S_COOLDOWN;
          end
        end
        S_COOLDOWN: begin
          if (enable_draw) begin
            if (cd_cnt >= CD_LAST) begin
              state_n  = S_ARMED;
              cd_cnt_n = 8'd0;
            end else begin
              cd_cnt_n = cd_cnt + 8'd1;
            end
          end
        end
        S_DESTROYED: destroyed_n = 1'b1;
        default: ;
      endcase
    end
  end

  // Registered outputs and cooldown counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fire           <= 1'b0;
      car_destroyed  <= 1'b0;
      hits_remaining <= 4'd0;
      cd_cnt         <= 8'd0;
`ifdef TOWER_LEDR_EN
      LEDR           <= 4'd0;
`endif
    end else begin
      fire           <= fire_n;
      car_destroyed  <= destroyed_n;
      hits_remaining <= hits_n;
      cd_cnt         <= cd_cnt_n;
`ifdef TOWER_LEDR_EN
      LEDR           <= state_leds(state_n);
`endif
    end
  end

endmodule

// File: tb/tb_tower_targeting.sv
// Directed bench for tower_targeting with a per-cycle reference model and literal spot checks.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_tower_targeting;

  localparam int TX = 80, TY = 60, RNG = 20, CD = 30, HP = 5;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        initiate = 1'b0;
  logic        enable_draw = 1'b0;
  logic        car_done = 1'b0;
  logic [14:0] car_location = '0;
  logic        car_destroyed;
  logic        fire;
  logic [3:0]  hits_remaining;
`ifdef TOWER_LEDR_EN
  logic [3:0]  LEDR;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  tower_targeting dut (
    .clk            (clk),
    .resetn         (resetn),
    .initiate       (initiate),
    .enable_draw    (enable_draw),
    .car_done       (car_done),
    .car_location   (car_location),
    .car_destroyed  (car_destroyed),
    .fire           (fire),
    .hits_remaining (hits_remaining)
`ifdef TOWER_LEDR_EN
    ,
    .LEDR           (LEDR)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (game rules, countdown of frames) ----------------
  int m_health = 0;
  bit m_ready = 0;       // tower may shoot
  int m_frames_left = 0; // frames still to wait before re-arming
  bit m_destroyed = 0;
  bit m_fire = 0;

  function automatic bit near(input logic [14:0] loc);
    int x, y, ax, ay;
    x  = int'(loc[14:7]);
    y  = int'(loc[6:0]);
    ax = (x > TX) ? x - TX : TX - x;
    ay = (y > TY) ? y - TY : TY - y;
    return (ax <= RNG) && (ay <= RNG);
  endfunction

  always @(posedge clk or negedge resetn) begin
    bit shot;
    if (!resetn) begin
      m_health = 0; m_ready = 0; m_frames_left = 0; m_destroyed = 0; m_fire = 0;
    end else begin
      shot   = m_fire;
      m_fire = 0;
      if (initiate) begin
        m_health = HP; m_ready = 1; m_frames_left = 0; m_destroyed = 0;
      end else if (shot) begin
        m_health = m_health - 1;
        if (m_health == 0) m_destroyed = 1;
        else m_frames_left = CD;
      end else if (m_frames_left > 0) begin
        if (enable_draw) begin
          m_frames_left = m_frames_left - 1;
          if (m_frames_left == 0) m_ready = 1;
        end
      end else if (m_ready && !m_destroyed && car_done && near(car_location)) begin
        m_fire  = 1;
        m_ready = 0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("model_fire", 8'(fire), 8'(m_fire));
    check("model_destroyed", 8'(car_destroyed), 8'(m_destroyed));
    check("model_hits", 8'(hits_remaining), 8'(m_health));
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [14:0] loc(input int x, input int y);
    return {8'(x), 7'(y)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    initiate = 0; car_done = 0; enable_draw = 0;
  endtask

  task automatic send_car(input int x, input int y);
    car_location = loc(x, y);
    car_done = 1;
    step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      enable_draw = 1;
      step();
    end
  endtask

  initial begin
    #2 resetn = 0;
    step(); step();
    check("reset_fire", 8'(fire), 8'd0);
    check("reset_hits", 8'(hits_remaining), 8'd0);
    check("reset_destroyed", 8'(car_destroyed), 8'd0);
    resetn = 1;
    step();

    // 1: no shooting before initiate
    send_car(80, 60);
    check("gate_fire", 8'(fire), 8'd0);
    step();
    check("gate_hits", 8'(hits_remaining), 8'd0);

    // 2: single shot
    initiate = 1; step();
    check("init_hits", 8'(hits_remaining), 8'd5);
    check("init_destroyed", 8'(car_destroyed), 8'd0);
    send_car(70, 55);
    check("shot_fire", 8'(fire), 8'd1);
    check("shot_hits_hold", 8'(hits_remaining), 8'd5);
    step();
    check("shot_fire_off", 8'(fire), 8'd0);
    check("shot_hits_dec", 8'(hits_remaining), 8'd4);

    // 3: range boundary
    frames(CD);
    send_car(101, 60);
    check("bound_x101", 8'(fire), 8'd0);
    send_car(59, 60);
    check("bound_x59", 8'(fire), 8'd0);
    send_car(100, 40);
    check("bound_corner", 8'(fire), 8'd1);
    step();
    check("bound_hits", 8'(hits_remaining), 8'd3);

    // 4: cooldown length
    for (int i = 0; i < CD - 1; i++) begin
      frames(1);
      send_car(80, 60);
      check("cool_blocked", 8'(fire), 8'd0);
    end
    enable_draw = 1; car_location = loc(80, 60); car_done = 1; step();
    check("cool_exit_ignores_car", 8'(fire), 8'd0);
    send_car(80, 60);
    check("cool_rearmed", 8'(fire), 8'd1);
    step();
    check("cool_hits", 8'(hits_remaining), 8'd2);

    // initiate beats a simultaneous in-range car_done
    initiate = 1; car_location = loc(80, 60); car_done = 1; step();
    check("init_wins_fire", 8'(fire), 8'd0);
    check("init_wins_hits", 8'(hits_remaining), 8'd5);

    // 5: destroy and re-arm
    for (int k = 1; k <= HP; k++) begin
      send_car(85, 65);
      check("kill_fire", 8'(fire), 8'd1);
      check("kill_not_yet", 8'(car_destroyed), 8'd0);
      step();
      check("kill_hits", 8'(hits_remaining), 8'(HP - k));
      if (k < HP) frames(CD);
    end
    check("destroyed_set", 8'(car_destroyed), 8'd1);
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) send_car(80, 60);
      else frames(1);
    end
    check("destroyed_held", 8'(car_destroyed), 8'd1);
    check("destroyed_no_fire", 8'(fire), 8'd0);
    initiate = 1; step();
    check("rearm_destroyed", 8'(car_destroyed), 8'd0);
    check("rearm_hits", 8'(hits_remaining), 8'd5);

    // 6: reset mid-cooldown
    send_car(80, 60);
    step();
    frames(3);
    #2 resetn = 0;
    #1;
    check("rst_async_fire", 8'(fire), 8'd0);
    check("rst_async_hits", 8'(hits_remaining), 8'd0);
    check("rst_async_destroyed", 8'(car_destroyed), 8'd0);
    step();
    resetn = 1;
    step();
    send_car(80, 60);
    check("rst_idle_no_fire", 8'(fire), 8'd0);
    step();
    check("rst_idle_hits", 8'(hits_remaining), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
